// File: rtl/snake_pkg.sv
// snake_pkg
// Shared types and defaults for the snake collision detector.
//   DEF_GRID_W / DEF_GRID_H / DEF_COORD_W : playfield and coordinate defaults
//   coord_t    : packed {x, y} cell coordinate
//   cd_state_t : detector FSM state
//   len_w()    : width of the snake length counter for a given MAX_LEN
package snake_pkg;

  localparam int DEF_GRID_W  = 32;
  localparam int DEF_GRID_H  = 24;
  localparam int DEF_COORD_W = 6;

  typedef struct packed {
    logic [DEF_COORD_W-1:0] x;
    logic [DEF_COORD_W-1:0] y;
  } coord_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WALL,
    ST_CHECK,
    ST_COMMIT,
    ST_DEAD
  } cd_state_t;

  // Enough bits to hold the values 0..max_len inclusive.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/segment_ring.sv
// segment_ring
// Ring buffer of snake body segments. Segment 0 (the head) lives at the
// head pointer; logical index k maps to physical slot (ptr + k) mod MAX_LEN.
// A push moves the pointer back one slot and writes the new head there, so
// the oldest entry (the tail once the ring is full) is overwritten.
// Ports:
//   clock, reset : clock and asynchronous active-high reset (loads the
//                  START_LEN initial segments (START_X-i, START_Y))
//   push         : write push_data as the new segment 0
//   push_data    : new head coordinate
//   rd_idx       : head-relative logical index to read
//   rd_data      : combinational read of segment rd_idx
module segment_ring
  import snake_pkg::*;
#(
  parameter int MAX_LEN   = 32,
  parameter int START_LEN = 3,
  parameter int START_X   = 16,
  parameter int START_Y   = 12,
  localparam int IDX_W    = $clog2(MAX_LEN)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  coord_t           push_data,
  input  logic [IDX_W-1:0] rd_idx,
  output coord_t           rd_data
);

  coord_t           mem_q [MAX_LEN];
  coord_t           mem_d [MAX_LEN];
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  function automatic coord_t init_seg(input int i);
    coord_t c;
    c = '0;
    if (i < START_LEN) begin
      c.x = DEF_COORD_W'(START_X - i);
      c.y = DEF_COORD_W'(START_Y);
    end
    return c;
  endfunction

  // Modular add that also works when MAX_LEN is not a power of two.
  function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] a,
                                               input logic [IDX_W-1:0] b);
    logic [IDX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (IDX_W+1)'(MAX_LEN)) s = s - (IDX_W+1)'(MAX_LEN);
    return s[IDX_W-1:0];
  endfunction

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    if (push) begin
      ptr_d = (ptr_q == '0) ? IDX_W'(MAX_LEN - 1) : ptr_q - 1'b1;
      mem_d[ptr_d] = push_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) mem_q[i] <= init_seg(i);
      ptr_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
    end
  end

  assign rd_data = mem_q[idx_add(ptr_q, rd_idx)];

endmodule

// File: rtl/snake_collision_detector.sv
// snake_collision_detector
// Checks each new head position against the walls and the snake's own body,
// one body segment per cycle, and commits the head into the segment ring.
// Optional feature: define SNAKE_WALL_WRAP_EN to make walls wrap instead of
// kill (GRID_W -> 0 and all-ones -> GRID_W-1, same for y with GRID_H).
// Ports:
//   clock, reset   : clock and asynchronous active-high reset
//   move_tick      : one-cycle pulse presenting head_x/head_y/grow
//   head_x, head_y : new head coordinate
//   grow           : food eaten this step
//   collision      : one-cycle pulse on a wall or self hit
//   busy           : a check is in progress
//   length         : current snake length
//   overrun        : sticky, a tick arrived while busy or dead
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for move_tick
// ST_WALL   | wall check (or wrap) on the latched head
// ST_CHECK  | compare latched head with segment k, one per cycle
// ST_COMMIT | push head into the ring, update length
// ST_DEAD   | collision seen; frozen until reset
module snake_collision_detector
  import snake_pkg::*;
#(
  parameter int GRID_W    = DEF_GRID_W,
  parameter int GRID_H    = DEF_GRID_H,
  parameter int COORD_W   = DEF_COORD_W,
  parameter int MAX_LEN   = 32,
  parameter int START_LEN = 3,
  parameter int START_X   = 16,
  parameter int START_Y   = 12,
  localparam int LEN_W    = len_w(MAX_LEN)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               move_tick,
  input  logic [COORD_W-1:0] head_x,
  input  logic [COORD_W-1:0] head_y,
  input  logic               grow,
  output logic               collision,
  output logic               busy,
  output logic [LEN_W-1:0]   length,
  output logic               overrun
);

  localparam int IDX_W = $clog2(MAX_LEN);

  cd_state_t        state_q, state_d;
  coord_t           head_q, head_d;
  logic             grow_q, grow_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             col_q, col_d;
  logic             ovr_q, ovr_d;

  coord_t           seg;
  coord_t           head_wr;
  logic             wall_hit;
  logic             seg_match;
  logic [LEN_W-1:0] last_k;

  segment_ring #(
    .MAX_LEN   (MAX_LEN),
    .START_LEN (START_LEN),
    .START_X   (START_X),
    .START_Y   (START_Y)
  ) u_ring (
    .clock     (clock),
    .reset     (reset),
    .push      (state_q == ST_COMMIT),
    .push_data (head_q),
    .rd_idx    (k_q),
    .rd_data   (seg)
  );

  // Wall handling on the latched head; head_wr is what gets stored.
  always_comb begin
    head_wr  = head_q;
    wall_hit = 1'b0;
`ifdef SNAKE_WALL_WRAP_EN
    if (head_q.x == COORD_W'(GRID_W))    head_wr.x = '0;
    else if (head_q.x == '1)             head_wr.x = COORD_W'(GRID_W - 1);
    if (head_q.y == COORD_W'(GRID_H))    head_wr.y = '0;
    else if (head_q.y == '1)             head_wr.y = COORD_W'(GRID_H - 1);
`else
    wall_hit = (head_q.x >= COORD_W'(GRID_W)) || (head_q.y >= COORD_W'(GRID_H));
`endif
  end

  assign seg_match = (seg == head_q);
  // Without growth the tail vacates this step, so the scan stops one short.
  assign last_k    = grow_q ? (len_q - LEN_W'(1)) : (len_q - LEN_W'(2));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      head_q  <= '0;
      grow_q  <= 1'b0;
      k_q     <= '0;
      len_q   <= LEN_W'(START_LEN);
      col_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      grow_q  <= grow_d;
      k_q     <= k_d;
      len_q   <= len_d;
      col_q   <= col_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    grow_d  = grow_q;
    k_d     = k_q;
    len_d   = len_q;
    col_d   = 1'b0;
    ovr_d   = ovr_q;

    if (move_tick && (state_q != ST_IDLE)) ovr_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (move_tick) begin
          head_d.x = head_x;
          head_d.y = head_y;
          grow_d   = grow;
          state_d  = ST_WALL;
        end
      end
      ST_WALL: begin
        if (wall_hit) begin
          col_d   = 1'b1;
          state_d = ST_DEAD;
        end else begin
          head_d  = head_wr;
          k_d     = '0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (seg_match) begin
          col_d   = 1'b1;
          state_d = ST_DEAD;
        end else if (LEN_W'(k_q) == last_k) begin
          state_d = ST_COMMIT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        // At MAX_LEN the push itself overwrites the tail, so length holds.
        if (grow_q && (len_q < LEN_W'(MAX_LEN))) len_d = len_q + 1'b1;
        state_d = ST_IDLE;
      end
      ST_DEAD: begin
        state_d = ST_DEAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == ST_WALL) || (state_q == ST_CHECK) || (state_q == ST_COMMIT);
    collision = col_q;
    length    = len_q;
    overrun   = ovr_q;
  end

endmodule

// File: tb/tb_snake_collision_detector.sv
module tb_snake_collision_detector;

  localparam int GRID_W    = 32;
  localparam int GRID_H    = 24;
  localparam int MAX_LEN   = 32;
  localparam int START_LEN = 3;
  localparam int START_X   = 16;
  localparam int START_Y   = 12;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       move_tick = 1'b0;
  logic [5:0] head_x = '0;
  logic [5:0] head_y = '0;
  logic       grow = 1'b0;
  logic       collision;
  logic       busy;
  logic [5:0] length;
  logic       overrun;

  snake_collision_detector #(
    .GRID_W    (GRID_W),
    .GRID_H    (GRID_H),
    .COORD_W   (6),
    .MAX_LEN   (MAX_LEN),
    .START_LEN (START_LEN),
    .START_X   (START_X),
    .START_Y   (START_Y)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .move_tick (move_tick),
    .head_x    (head_x),
    .head_y    (head_y),
    .grow      (grow),
    .collision (collision),
    .busy      (busy),
    .length    (length),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: body as a list of cells, head first.
  typedef struct { int x; int y; } pt_t;
  pt_t body[$];
  int  m_dead;
  int  m_ovr;

  function automatic void model_reset();
    body.delete();
    for (int i = 0; i < START_LEN; i++) body.push_back('{START_X - i, START_Y});
    m_dead = 0;
    m_ovr  = 0;
  endfunction

  function automatic void model_step(input int x, input int y, input int g,
                                     output int ecol, output int ecyc);
    pt_t h;
    int  n;
    int  len;
    h = '{x, y};
    ecol = 0;
`ifdef SNAKE_WALL_WRAP_EN
    if (h.x == GRID_W) h.x = 0; else if (h.x == 63) h.x = GRID_W - 1;
    if (h.y == GRID_H) h.y = 0; else if (h.y == 63) h.y = GRID_H - 1;
`else
    if (h.x >= GRID_W || h.y >= GRID_H) begin
      ecol = 1; ecyc = 1; m_dead = 1;
      return;
    end
`endif
    len = body.size();
    n = g ? len : len - 1;
    for (int k = 0; k < n; k++) begin
      if (body[k].x == h.x && body[k].y == h.y) begin
        ecol = 1; ecyc = k + 2; m_dead = 1;
        return;
      end
    end
    ecyc = n + 2;
    body.push_front(h);
    if (!(g != 0 && len < MAX_LEN)) void'(body.pop_back());
  endfunction

  task automatic apply_reset();
    @(negedge clock);
    move_tick = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_collision"}, collision, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_length"}, length, START_LEN);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  // Presents one tick, then counts edges until busy falls.
  task automatic run_step(input int x, input int y, input int g,
                          output int col, output int cyc);
    @(negedge clock);
    head_x = x[5:0];
    head_y = y[5:0];
    grow = g[0];
    move_tick = 1'b1;
    @(posedge clock);
    @(negedge clock);
    move_tick = 1'b0;
    check("busy_after_tick", busy, 1);
    col = 0;
    cyc = -1;
    for (int c = 1; c <= MAX_LEN + 6; c++) begin
      @(negedge clock);
      if (collision) col = 1;
      if (!busy) begin
        cyc = c;
        break;
      end
    end
    check("step_done_in_budget", (cyc >= 0) ? 1 : 0, 1);
    @(negedge clock);
    check("collision_one_cycle", collision, 0);
  endtask

  task automatic model_checked_step(input int x, input int y, input int g);
    int ecol, ecyc, col, cyc;
    model_step(x, y, g, ecol, ecyc);
    run_step(x, y, g, col, cyc);
    check("model_collision", col, ecol);
    check("model_cycles", cyc, ecyc);
    check("model_length", length, body.size());
    check("model_overrun", overrun, m_ovr);
  endtask

  task automatic dead_tick();
    int seen;
    seen = 0;
    @(negedge clock);
    head_x = 6'd1;
    head_y = 6'd1;
    move_tick = 1'b1;
    @(posedge clock);
    @(negedge clock);
    move_tick = 1'b0;
    repeat (4) begin
      if (collision || busy) seen = 1;
      @(negedge clock);
    end
    m_ovr = 1;
    check("dead_tick_quiet", seen, 0);
    check("dead_overrun", overrun, 1);
    check("dead_length", length, body.size());
  endtask

  typedef struct {
    int x; int y; int g;
    int ecol; int ecyc; int elen;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int col, cyc, hx, hy, dir, len_before;

    // Sequence from reset; last two entries are the tail-chase pair.
    vecs[0] = '{17, 12, 0, 0, 4, 3};
    vecs[1] = '{18, 12, 1, 0, 5, 4};
    vecs[2] = '{18, 13, 0, 0, 5, 4};
    vecs[3] = '{17, 13, 0, 0, 5, 4};
    vecs[4] = '{17, 12, 0, 0, 5, 4};
    vecs[5] = '{18, 12, 1, 1, 5, 4};

    repeat (2) @(negedge clock);
    apply_reset();
    check_reset_values("reset0");

    for (int i = 0; i < 6; i++) begin
      run_step(vecs[i].x, vecs[i].y, vecs[i].g, col, cyc);
      check($sformatf("vec%0d_collision", i), col, vecs[i].ecol);
      check($sformatf("vec%0d_cycles", i), cyc, vecs[i].ecyc);
      check($sformatf("vec%0d_length", i), length, vecs[i].elen);
    end

    // Self hit at k=1, then ticks while dead.
    apply_reset();
    run_step(15, 12, 0, col, cyc);
    check("selfhit_collision", col, 1);
    check("selfhit_cycles", cyc, 3);
    check("selfhit_length", length, 3);
    body.delete();
    for (int i = 0; i < 3; i++) body.push_back('{0, 0});
    dead_tick();
    dead_tick();

    // Wall at x=32.
    apply_reset();
    run_step(32, 5, 0, col, cyc);
`ifdef SNAKE_WALL_WRAP_EN
    check("wall_wrap_collision", col, 0);
    check("wall_wrap_cycles", cyc, 4);
    run_step(0, 5, 0, col, cyc);
    check("wrap_stored_head_hit", col, 1);
    check("wrap_stored_head_cycles", cyc, 2);
`else
    check("wall_collision", col, 1);
    check("wall_cycles", cyc, 1);
    check("wall_length", length, 3);
`endif

    // Grow 40 times along an L-shaped path.
    apply_reset();
    hx = START_X;
    hy = START_Y;
    for (int s = 0; s < 40; s++) begin
      if (hx < GRID_W - 1 && hy == START_Y) hx++;
      else if (hy < GRID_H - 1 && hx == GRID_W - 1) hy++;
      else hx--;
      model_checked_step(hx, hy, 1);
    end
    check("grow_saturated_length", length, MAX_LEN);

    // Reset during CHECK.
    apply_reset();
    @(negedge clock);
    head_x = 6'd17;
    head_y = 6'd12;
    grow = 1'b0;
    move_tick = 1'b1;
    @(posedge clock);
    #1 move_tick = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_length", length, START_LEN);
    col = 0;
    repeat (3) begin
      @(negedge clock);
      if (collision) col = 1;
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (collision) col = 1;
    end
    check("midreset_no_pulse", col, 0);
    check_reset_values("midreset");
    model_reset();
    model_checked_step(15, 12, 0);

    // Random walks checked against the model.
    for (int r = 0; r < 6; r++) begin
      apply_reset();
      for (int s = 0; s < 60 && m_dead == 0; s++) begin
        dir = $urandom_range(0, 3);
        hx = body[0].x;
        hy = body[0].y;
        case (dir)
          0: hx = hx + 1;
          1: hx = hx - 1;
          2: hy = hy + 1;
          default: hy = hy - 1;
        endcase
        hx = hx & 63;
        hy = hy & 63;
        len_before = body.size();
        model_checked_step(hx, hy, ($urandom_range(0, 3) == 0) ? 1 : 0);
        if (m_dead != 0) check("rand_dead_length_frozen", length, len_before);
      end
      if (m_dead != 0) dead_tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
